wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
//   Weighted round-robin arbiter with grant hold and per-client quantum; successor to the basic RR arbiter.
//   Grants one of NUM_CLIENTS requesters at a time with a registered one-hot grant.
//   The owner keeps the grant while it requests, for up to weight[i] consecutive cycles, then rotates.
//   Sits in front of shared resources (bus port, memory bank) where burst fairness is needed.
// PARAMETERS
//   NUM_CLIENTS  4   number of requesters, >=2
//   WEIGHT_W     4   width of each per-client weight / quantum counter
// PORTS
//   clk          in   1                      single clock, rising edge
//   rst          in   1                      synchronous reset, active-high
//   req          in   NUM_CLIENTS            per-client request level, held until served
//   weight       in   NUM_CLIENTS*WEIGHT_W   client i quantum at [i*WEIGHT_W +: WEIGHT_W]; quasi-static
//   grant        out  NUM_CLIENTS            one-hot (or zero) registered grant
//   grant_valid  out  1                      |grant, registered
//   grant_idx    out  $clog2(NUM_CLIENTS)    binary index of owner; holds last owner when idle
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge)
//     grant=0, grant_valid=0, grant_idx=0, ptr=client 0, cnt=0, state=IDLE.
//     Reset mid-burst drops the grant on that edge.
//   Definitions
//     wt(i) = weight[i], with 0 treated as 1.
//     pick(v,p) = first set bit of v scanning cyclically from index p upward (wrap N-1 -> 0).
//   States
//     IDLE: no owner. BUSY: owner g = grant_idx, cnt = cycles granted in the current quantum.
//   IDLE
//     |req=0 -> stay IDLE.
//     Otherwise -> g'=pick(req,ptr), cnt=1, BUSY.
//     Latency: req rising at edge k is granted at edge k+1.
//   BUSY, hold
//     req[g]=1 and cnt<wt(g) -> keep g, cnt++.
//   BUSY, release
//     Release if req[g]=0 or cnt==wt(g). Then ptr=(g+1)%N and:
//       - any req set -> g'=pick(req,(g+1)%N), cnt=1, stay BUSY. No idle bubble between owners.
//       - none set -> IDLE, grant=0.
//   Quantum expiry
//     If only g still requests, g is re-granted with a fresh quantum.
//     This falls out of pick wrapping back to g.
//   Simultaneous events
//     Release and new requests on the same edge: the new requests take part in the pick.
//     A req dropping on the edge it would be granted is not granted (pick uses current req).
//   Widths
//     cnt is WEIGHT_W bits and never exceeds wt(g), so it cannot overflow.
//     ptr is stored one-hot or as an index; both are permitted and must not be visible at the ports.
//   Weight changes
//     weight is sampled every cycle. Lowering wt(g) below cnt releases on the next edge (compare uses >=).
//   Invariants
//     grant is one-hot or zero; grant_valid == |grant.
//     grant[i] implies req[i] was 1 at the prior edge.
// STRUCTURE
//   Package wrr_arb_pkg: IDX_W = $clog2(NUM_CLIENTS) helper, state enum {IDLE, BUSY},
//     onehot-to-index function.
//   Sub-module rr_pick: combinational masked priority picker.
//     Doubled-vector method; inputs req and start index; outputs one-hot and found flag.
//   Top holds the FSM, ptr, cnt and the output registers.
// TESTING
//   1. rst=1 for 2 cycles, req=4'b1111 -> grant=0, grant_valid=0, grant_idx=0 while in reset.
//   2. Hold and rotate: weights all 1, req=4'b1111 steady -> grant 0001,0010,0100,1000,0001 on
//      consecutive cycles.
//   3. Weighted: weight={1,1,1,3} (client0=3), req=4'b0011 -> grant 01,01,01,10,01,01,01,10.
//   4. Early release: client2 granted, weight=4, req[2] drops after 2 cycles while req[0]=1 ->
//      grant 0001 on the next edge, no zero cycle.
//   5. Lone requester: req=4'b0100, weight[2]=2 -> grant 0100 held continuously, cnt cycles 1,2,1,2.
//      Then req=0 -> grant=0 the next cycle.
//   6. Reset mid-burst: rst pulses during a weight-3 burst -> grant=0 the next edge; ptr back to 0.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wrr_arb_pkg : shared types and helpers for the weighted round-robin arbiter |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package wrr_arb_pkg;

  localparam int unsigned C_MAX_CLIENTS = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index width for n clients, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // OR-reduction of set-bit indices: exact for one-hot input, cheap in gates.
  function automatic int unsigned onehot_to_idx(input logic [C_MAX_CLIENTS-1:0] v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < C_MAX_CLIENTS; i++) begin
      if (v[i]) r = r | i;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational cyclic priority picker starting at i_start          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_onehot,
  output logic             o_found
);

  localparam int unsigned C_DW = 2 * N;

  logic [C_DW-1:0] w_dbl;
  logic [C_DW-1:0] w_mask;
  logic [C_DW-1:0] w_masked;
  logic [C_DW-1:0] w_lowest;

  // Lower copy masked below i_start; the upper copy supplies the wrap-around.
  assign w_dbl    = {i_req, i_req};
  assign w_mask   = ~((C_DW'(1) << i_start) - C_DW'(1));
  assign w_masked = w_dbl & w_mask;
  assign w_lowest = w_masked & (~w_masked + C_DW'(1));

  assign o_onehot = w_lowest[N-1:0] | w_lowest[C_DW-1:N];
  assign o_found  = |i_req;

endmodule
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wrr_arbiter : weighted round-robin arbiter with grant hold and quantum      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wrr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned WEIGHT_W    = 4,
  localparam int unsigned IDX_W      = idx_w(NUM_CLIENTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
  output logic [NUM_CLIENTS-1:0]          grant,
  output logic                            grant_valid,
  output logic [IDX_W-1:0]                grant_idx
);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic [WEIGHT_W-1:0]    r_cnt;
  logic [NUM_CLIENTS-1:0] r_grant;
  logic                   r_grant_valid;
  logic [IDX_W-1:0]       r_grant_idx;

  logic [WEIGHT_W-1:0]    w_wt_raw;
  logic [WEIGHT_W-1:0]    w_wt_g;
  logic                   w_release;
  logic [IDX_W-1:0]       w_next_ptr;
  logic [IDX_W-1:0]       w_start;
  logic [NUM_CLIENTS-1:0] w_pick;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick_idx;

  assign w_wt_raw  = weight[r_grant_idx*WEIGHT_W +: WEIGHT_W];
  assign w_wt_g    = (w_wt_raw == '0) ? WEIGHT_W'(1) : w_wt_raw;
  // >= so that a weight lowered mid-quantum releases on the next edge.
  assign w_release = !req[r_grant_idx] || (r_cnt >= w_wt_g);

  assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : r_grant_idx + IDX_W'(1);
  assign w_start    = (r_state == IDLE) ? r_ptr : w_next_ptr;

  rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_start  (w_start),
    .o_onehot (w_pick),
    .o_found  (w_found)
  );

  assign w_pick_idx = IDX_W'(onehot_to_idx(C_MAX_CLIENTS'(w_pick)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state       <= BUSY;
            r_cnt         <= WEIGHT_W'(1);
            r_grant       <= w_pick;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_pick_idx;
          end
        end
        BUSY: begin
          if (!w_release) begin
            r_cnt <= r_cnt + WEIGHT_W'(1);
          end else begin
            r_ptr <= w_next_ptr;
            if (w_found) begin
              r_cnt         <= WEIGHT_W'(1);
              r_grant       <= w_pick;
              r_grant_valid <= 1'b1;
              r_grant_idx   <= w_pick_idx;
            end else begin
              r_state       <= IDLE;
              r_cnt         <= '0;
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wrr_arbiter : directed and randomized checks against a behavioural model |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_wrr_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] weight;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [1:0]     grant_idx;

  int checks = 0;
  int errors = 0;

  // Model state: owner index (-1 when idle), cycles in quantum, rotation start, last owner.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_last  = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.NUM_CLIENTS(N), .WEIGHT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int wt(input int i);
    int w;
    w = int'(weight[i*W +: W]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    return e;
  endfunction

  task automatic model_update();
    int p;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_last = 0;
    end else if (m_owner < 0) begin
      p = pick(req, m_ptr);
      if (p >= 0) begin m_owner = p; m_cnt = 1; m_last = p; end
    end else if (req[m_owner] && m_cnt < wt(m_owner)) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_ptr = (m_owner + 1) % N;
      p = pick(req, m_ptr);
      if (p >= 0) begin m_owner = p; m_cnt = 1; m_last = p; end
      else begin m_owner = -1; m_cnt = 0; end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    weight = {W'(w3), W'(w2), W'(w1), W'(w0)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    set_weights(1, 1, 1, 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: grant=%b valid=%b idx=%0d, required 0000/0/0",
                 c, grant, grant_valid, grant_idx);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rotate();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    set_weights(1, 1, 1, 1);
    req = 4'b0000;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (grant !== exp_seq[c] || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotate cyc%0d: grant=%b valid=%b, required %b/1", c, grant, grant_valid, exp_seq[c]);
      end
    end
  endtask

  task automatic test_weighted();
    logic [N-1:0] exp_seq [8];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    set_weights(3, 1, 1, 1);
    req = 4'b0000;
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (grant !== exp_seq[c]) begin
        errors++;
        $display("FAIL weighted cyc%0d: grant=%b, required %b", c, grant, exp_seq[c]);
      end
    end
  endtask

  task automatic test_early_release();
    set_weights(4, 4, 4, 4);
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100) begin
        errors++;
        $display("FAIL early_hold cyc%0d: grant=%b, required 0100", c, grant);
      end
    end
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL early_release: grant=%b valid=%b idx=%0d, required 0001/1/0", grant, grant_valid, grant_idx);
    end
  endtask

  task automatic test_lone();
    set_weights(1, 1, 2, 1);
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
        errors++;
        $display("FAIL lone cyc%0d: grant=%b valid=%b idx=%0d, required 0100/1/2", c, grant, grant_valid, grant_idx);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL lone_drop: grant=%b valid=%b idx=%0d, required 0000/0/2", grant, grant_valid, grant_idx);
    end
  endtask

  task automatic test_reset_mid_burst();
    set_weights(1, 3, 1, 1);
    req = 4'b0000;
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL midburst_setup: grant=%b, required 0010", grant);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL midburst_reset: grant=%b valid=%b idx=%0d, required 0000/0/0", grant, grant_valid, grant_idx);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL midburst_ptr: grant=%b, required 0001", grant);
    end
  endtask

  task automatic test_random();
    req = 4'b0000;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(60) == 0) weight = N*W'($urandom);
      rst = ($urandom_range(250) == 0);
      tick();
      checks++;
      if (grant !== exp_grant() || grant_valid !== (m_owner >= 0) || grant_idx !== 2'(m_last)) begin
        errors++;
        $display("FAIL random cyc%0d: grant=%b valid=%b idx=%0d, required %b/%0b/%0d",
                 c, grant, grant_valid, grant_idx, exp_grant(), (m_owner >= 0), m_last);
      end
      checks++;
      if (!$onehot0(grant) || grant_valid !== (|grant)) begin
        errors++;
        $display("FAIL random_onehot cyc%0d: grant=%b valid=%b, required one-hot/zero with valid=|grant",
                 c, grant, grant_valid);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    weight = '0;
    test_reset();
    test_rotate();
    test_weighted();
    test_early_release();
    test_lone();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
